// File: rtl/piezo_pkg.sv
// Shared constants for the piezo sound arbiter: state encodings, grant bit
// positions, tone frequencies, gate periods and the engine-tone law.
package piezo_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_HORN  = 3'd1;
  localparam state_t S_ESS   = 3'd2;
  localparam state_t S_REV   = 3'd3;
  localparam state_t S_CLICK = 3'd4;
  localparam state_t S_ENG   = 3'd5;

  localparam int GRANT_W   = 5;
  localparam int IDX_HORN  = 0;
  localparam int IDX_ESS   = 1;
  localparam int IDX_REV   = 2;
  localparam int IDX_CLICK = 3;
  localparam int IDX_ENG   = 4;

  localparam int HORN_HZ  = 440;
  localparam int GATED_HZ = 1000;
  localparam int CLICK_HZ = 2000;

  localparam int ESS_GATE_MS = 100;
  localparam int REV_GATE_MS = 500;

  localparam int HP_W         = 24;
  localparam int ENG_HP_MIN   = 100;
  localparam int ENG_HP_MAX   = 4000;
  localparam int ENG_HP_SLOPE = 1;

  function automatic logic [HP_W-1:0] half_period(input int clk_freq, input int tone_hz);
    return HP_W'(clk_freq / (2 * tone_hz));
  endfunction

  // Product is formed at 32 bits and clamped before subtraction, so it can never wrap.
  function automatic logic [HP_W-1:0] eng_half_period(input logic [13:0] rpm);
    logic [31:0] prod;
    prod = 32'(rpm) * 32'(ENG_HP_SLOPE);
    if (prod >= 32'(ENG_HP_MAX - ENG_HP_MIN)) begin
      return HP_W'(ENG_HP_MIN);
    end
    return HP_W'(32'(ENG_HP_MAX) - prod);
  endfunction

endpackage

// File: rtl/piezo_tone_gen.sv
// Programmable half-period square-wave generator with synchronous restart.
// The half-period is sampled only at restart and at each toggle.
module piezo_tone_gen
  import piezo_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            restart_i,
  input  logic            en_i,
  input  logic [HP_W-1:0] half_period_i,
  output logic            tone_o
);

  logic [HP_W-1:0] cnt_q, cnt_d;
  logic [HP_W-1:0] hp_q, hp_d;
  logic            tone_q, tone_d;

  always_comb begin
    cnt_d  = cnt_q;
    hp_d   = hp_q;
    tone_d = tone_q;
    if (restart_i || !en_i) begin
      cnt_d  = '0;
      hp_d   = half_period_i;
      tone_d = 1'b0;
    end else if (cnt_q >= hp_q - HP_W'(1)) begin
      cnt_d  = '0;
      hp_d   = half_period_i;
      tone_d = ~tone_q;
    end else begin
      cnt_d  = cnt_q + HP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      hp_q   <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hp_q   <= hp_d;
      tone_q <= tone_d;
    end
  end

  assign tone_o = tone_q;

endmodule

// File: rtl/piezo_arbiter.sv
// Fixed-priority piezo arbiter: horn > ESS > reverse > click > engine.
// The engine tone exists only when PIEZO_ENGINE_TONE_EN is defined.
module piezo_arbiter
  import piezo_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int CLICK_MS = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_horn,
  input  logic               req_ess,
  input  logic               req_reverse,
  input  logic               req_click,
  input  logic               engine_on,
  input  logic [13:0]        rpm,
  output logic               piezo_out,
  output logic [GRANT_W-1:0] grant
);

  localparam int MS_DIV  = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
  localparam int MS_W    = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int GATE_W  = 10;
  localparam int CLICK_W = 16;

  localparam logic [MS_W-1:0]    MS_LAST    = MS_W'(MS_DIV - 1);
  localparam logic [GATE_W-1:0]  ESS_LAST   = GATE_W'(ESS_GATE_MS - 1);
  localparam logic [GATE_W-1:0]  REV_LAST   = GATE_W'(REV_GATE_MS - 1);
  localparam logic [CLICK_W-1:0] CLICK_LAST = CLICK_W'(CLICK_MS - 1);

  localparam logic [HP_W-1:0] HP_HORN  = half_period(CLK_FREQ, HORN_HZ);
  localparam logic [HP_W-1:0] HP_GATED = half_period(CLK_FREQ, GATED_HZ);
  localparam logic [HP_W-1:0] HP_CLICK = half_period(CLK_FREQ, CLICK_HZ);

  state_t               state_q, state_d;
  logic [GRANT_W-1:0]   grant_q, grant_d;
  logic [MS_W-1:0]      ms_cnt_q, ms_cnt_d;
  logic [GATE_W-1:0]    gate_ms_q, gate_ms_d;
  logic                 gate_on_q, gate_on_d;
  logic [CLICK_W-1:0]   click_ms_q, click_ms_d;
  logic                 click_prev_q;
  logic                 click_pend_q, click_pend_d;

  logic                 tick;
  logic                 state_chg;
  logic                 click_rise;
  logic                 click_done;
  logic                 gated;
  logic [GATE_W-1:0]    gate_last;
  logic                 tone_restart;
  logic                 tone_en;
  logic [HP_W-1:0]      hp_sel;

`ifdef PIEZO_ENGINE_TONE_EN
  logic [HP_W-1:0]      eng_hp;
  assign eng_hp = eng_half_period(rpm);
`else
  logic unused_eng;
  assign unused_eng = ^{engine_on, rpm};
`endif

  assign tick       = (ms_cnt_q == MS_LAST);
  assign click_rise = req_click & ~click_prev_q;
  assign click_done = (state_q == S_CLICK) && tick && (click_ms_q == CLICK_LAST);

  // Edges arriving while a click is already pending fold into it.
  assign click_pend_d = (click_pend_q | click_rise) & ~click_done;

  always_comb begin
    state_d = S_IDLE;
    if (req_horn) begin
      state_d = S_HORN;
    end else if (req_ess) begin
      state_d = S_ESS;
    end else if (req_reverse) begin
      state_d = S_REV;
    end else if (click_pend_d) begin
      state_d = S_CLICK;
`ifdef PIEZO_ENGINE_TONE_EN
    end else if (engine_on) begin
      state_d = S_ENG;
`endif
    end
  end

  assign state_chg = (state_d != state_q);

  always_comb begin
    grant_d            = '0;
    grant_d[IDX_HORN]  = (state_d == S_HORN);
    grant_d[IDX_ESS]   = (state_d == S_ESS);
    grant_d[IDX_REV]   = (state_d == S_REV);
    grant_d[IDX_CLICK] = (state_d == S_CLICK);
    grant_d[IDX_ENG]   = (state_d == S_ENG);
  end

  // The ms divider realigns on every state change so gate and burst timing start exactly at entry.
  assign ms_cnt_d = (state_chg || tick) ? '0 : ms_cnt_q + MS_W'(1);

  assign gated     = (state_q == S_ESS) || (state_q == S_REV);
  assign gate_last = (state_q == S_ESS) ? ESS_LAST : REV_LAST;

  always_comb begin
    gate_ms_d = gate_ms_q;
    gate_on_d = gate_on_q;
    if (state_chg) begin
      gate_ms_d = '0;
      gate_on_d = 1'b1;
    end else if (tick && gated) begin
      if (gate_ms_q == gate_last) begin
        gate_ms_d = '0;
        gate_on_d = ~gate_on_q;
      end else begin
        gate_ms_d = gate_ms_q + GATE_W'(1);
      end
    end
  end

  always_comb begin
    click_ms_d = click_ms_q;
    if (state_chg || (state_q != S_CLICK)) begin
      click_ms_d = '0;
    end else if (tick) begin
      click_ms_d = click_ms_q + CLICK_W'(1);
    end
  end

  always_comb begin
    case (state_d)
      S_HORN:  hp_sel = HP_HORN;
      S_ESS:   hp_sel = HP_GATED;
      S_REV:   hp_sel = HP_GATED;
      S_CLICK: hp_sel = HP_CLICK;
`ifdef PIEZO_ENGINE_TONE_EN
      S_ENG:   hp_sel = eng_hp;
`endif
      default: hp_sel = HP_HORN;
    endcase
  end

  // Tone restarts on entry and at each gate-on edge so the first half-period is always full.
  assign tone_restart = state_chg | (gate_on_d & ~gate_on_q);
  assign tone_en      = (state_d != S_IDLE) & gate_on_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      ms_cnt_q     <= '0;
      gate_ms_q    <= '0;
      gate_on_q    <= 1'b0;
      click_ms_q   <= '0;
      click_prev_q <= 1'b0;
      click_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ms_cnt_q     <= ms_cnt_d;
      gate_ms_q    <= gate_ms_d;
      gate_on_q    <= gate_on_d;
      click_ms_q   <= click_ms_d;
      click_prev_q <= req_click;
      click_pend_q <= click_pend_d;
    end
  end

  piezo_tone_gen u_tone (
    .clk           (clk),
    .rst_n         (rst_n),
    .restart_i     (tone_restart),
    .en_i          (tone_en),
    .half_period_i (hp_sel),
    .tone_o        (piezo_out)
  );

  assign grant = grant_q;

endmodule

// File: tb/tb_piezo_arbiter.sv
// Directed bench for piezo_arbiter at CLK_FREQ=20 kHz (1 ms = 20 clocks).
`timescale 1ns/1ps
module tb_piezo_arbiter;

  localparam int CLK_FREQ = 20_000;
  localparam int CLICK_MS = 20;
  localparam int HP_HORN  = 22;   // 20000 / 880
  localparam int HP_1K    = 10;
  localparam int HP_2K    = 5;
`ifdef PIEZO_ENGINE_TONE_EN
  localparam logic [4:0] ENG_G = 5'b10000;
`else
  localparam logic [4:0] ENG_G = 5'b00000;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_horn, req_ess, req_reverse, req_click, engine_on;
  logic [13:0] rpm;
  logic        piezo_out;
  logic [4:0]  grant;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n, hi, t0, te, tc;

  always #5 clk = ~clk;

  piezo_arbiter #(.CLK_FREQ(CLK_FREQ), .CLICK_MS(CLICK_MS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_horn    (req_horn),
    .req_ess     (req_ess),
    .req_reverse (req_reverse),
    .req_click   (req_click),
    .engine_on   (engine_on),
    .rpm         (rpm),
    .piezo_out   (piezo_out),
    .grant       (grant)
  );

  task automatic step(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic check_g(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_n(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Clocks until piezo_out changes; -1 if it never does within the limit.
  task automatic wait_toggle(input int limit, output int k);
    logic prev;
    prev = piezo_out;
    k = 0;
    do begin
      step(1);
      k++;
    end while (piezo_out === prev && k < limit);
    if (piezo_out === prev) k = -1;
  endtask

  task automatic count_high(input int k, output int h);
    h = 0;
    for (int i = 0; i < k; i++) begin
      if (piezo_out !== 1'b0) h++;
      step(1);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_horn = 1'b0; req_ess = 1'b0; req_reverse = 1'b0;
    req_click = 1'b0; engine_on = 1'b0; rpm = '0;
    step(3);
    check_g("reset_grant", grant, 5'b00000);
    check_b("reset_piezo", piezo_out, 1'b0);
    rst_n = 1'b1;
    step(2);
    check_g("idle_grant", grant, 5'b00000);

    // Horn: continuous 440 Hz
    req_horn = 1'b1;
    step(1);
    check_g("horn_grant", grant, 5'b00001);
    check_b("horn_start_low", piezo_out, 1'b0);
    wait_toggle(100, n); check_n("horn_hp1", n, HP_HORN);
    wait_toggle(100, n); check_n("horn_hp2", n, HP_HORN);
    req_horn = 1'b0;
    step(1);
    check_g("horn_release", grant, 5'b00000);
    check_b("idle_piezo", piezo_out, 1'b0);

    // Simultaneous requests and release order
    req_horn = 1'b1; req_ess = 1'b1; req_reverse = 1'b1;
    step(1);
    check_g("multi_horn", grant, 5'b00001);
    req_horn = 1'b0;
    step(1);
    check_g("multi_ess", grant, 5'b00010);
    check_b("multi_chg_low", piezo_out, 1'b0);
    req_ess = 1'b0;
    step(1);
    check_g("multi_rev", grant, 5'b00100);
    req_reverse = 1'b0;
    step(1);
    check_g("multi_idle", grant, 5'b00000);

    // Reverse over engine: 500 ms on / 500 ms off
    engine_on = 1'b1; rpm = 14'd0;
    step(1);
    check_g("eng_base", grant, ENG_G);
    req_reverse = 1'b1;
    step(1);
    t0 = cyc;
    check_g("rev_grant", grant, 5'b00100);
    wait_toggle(50, n); check_n("rev_hp1", n, HP_1K);
    wait_toggle(50, n); check_n("rev_hp2", n, HP_1K);
    wait_until(t0 + 5000);
    wait_toggle(50, n); check_n("rev_hp_mid", n, HP_1K);
    wait_until(t0 + 10000);
    count_high(10000, hi);
    check_n("rev_off_phase", hi, 0);
    wait_toggle(50, n); check_n("rev_resume", n, HP_1K);
    req_reverse = 1'b0;
    step(1);
    check_g("rev_release", grant, ENG_G);
    check_b("rev_release_low", piezo_out, 1'b0);
    engine_on = 1'b0;
    step(1);
    check_g("eng_off", grant, 5'b00000);

    // Two click edges 5 ms apart merge into one 20 ms burst
    req_click = 1'b1;
    step(1);
    t0 = cyc;
    check_g("click_grant", grant, 5'b01000);
    req_click = 1'b0;
    wait_toggle(50, n); check_n("click_hp", n, HP_2K);
    wait_until(t0 + 100);
    req_click = 1'b1;
    step(1);
    req_click = 1'b0;
    wait_until(t0 + 399);
    check_g("click_last", grant, 5'b01000);
    step(1);
    check_g("click_end", grant, 5'b00000);
    check_b("click_end_low", piezo_out, 1'b0);
    step(100);
    check_g("click_merged", grant, 5'b00000);

    // Click preempted by ESS, then replayed in full
    req_click = 1'b1;
    step(1);
    t0 = cyc;
    check_g("click2_grant", grant, 5'b01000);
    req_click = 1'b0;
    wait_until(t0 + 199);
    req_ess = 1'b1;
    step(1);
    te = cyc;
    check_g("ess_preempt", grant, 5'b00010);
    check_b("ess_preempt_low", piezo_out, 1'b0);
    wait_toggle(50, n); check_n("ess_hp", n, HP_1K);
    wait_until(te + 2000);
    count_high(1000, hi);
    check_n("ess_off_phase", hi, 0);
    req_ess = 1'b0;
    step(1);
    tc = cyc;
    check_g("click_regrant", grant, 5'b01000);
    wait_toggle(50, n); check_n("click_regrant_hp", n, HP_2K);
    wait_until(tc + 399);
    check_g("click_full_last", grant, 5'b01000);
    step(1);
    check_g("click_full_end", grant, 5'b00000);

`ifdef PIEZO_ENGINE_TONE_EN
    // Engine tone law: hp = max(100, 4000 - rpm), applied at the next toggle
    engine_on = 1'b1; rpm = 14'd0;
    step(1);
    check_g("eng_grant", grant, 5'b10000);
    wait_toggle(5000, n); check_n("eng_rpm0", n, 4000);
    rpm = 14'd3000;
    wait_toggle(5000, n); check_n("eng_latched", n, 4000);
    wait_toggle(5000, n); check_n("eng_rpm3000", n, 1000);
    rpm = 14'd16383;
    wait_toggle(5000, n); check_n("eng_latched2", n, 1000);
    wait_toggle(5000, n); check_n("eng_rpm_max", n, 100);
    rpm = 14'd3850;
    wait_toggle(5000, n); check_n("eng_latched3", n, 100);
    wait_toggle(5000, n); check_n("eng_rpm3850", n, 150);
    rpm = 14'd3950;
    wait_toggle(5000, n); check_n("eng_latched4", n, 150);
    wait_toggle(5000, n); check_n("eng_clamp", n, 100);
    engine_on = 1'b0;
    step(1);
    check_g("eng_release", grant, 5'b00000);
`else
    engine_on = 1'b1; rpm = 14'd100;
    step(2);
    check_g("eng_ignored", grant, 5'b00000);
    check_b("eng_ignored_low", piezo_out, 1'b0);
    engine_on = 1'b0;
`endif

    // Asynchronous reset mid-horn with a click pending
    req_horn = 1'b1; req_click = 1'b1;
    step(1);
    check_g("rst_horn_grant", grant, 5'b00001);
    req_click = 1'b0;
    step(29);
    check_b("rst_horn_high", piezo_out, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_b("rst_async_piezo", piezo_out, 1'b0);
    check_g("rst_async_grant", grant, 5'b00000);
    req_horn = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(3);
    check_g("rst_no_pending", grant, 5'b00000);

    // req_click held high across reset release counts as an edge
    rst_n = 1'b0; req_click = 1'b1;
    step(1);
    check_g("rst_hold_grant", grant, 5'b00000);
    rst_n = 1'b1;
    step(1);
    check_g("click_after_reset", grant, 5'b01000);
    req_click = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
